// File: rtl/cla_nibble_sequencer.sv
// Feeds WIDTH-bit operands nibble-by-nibble (LSB first) through an external registered 4-bit CLA
// stage, chaining carry. Optional golden-adder self-check enabled by macro CLA_SELFCHECK_EN.
module cla_nibble_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLA_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_s,
    input  logic             cla_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             chk_err
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (CLA_LAT > 1) ? $clog2(CLA_LAT) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_nibble_sequencer: WIDTH must be a non-zero multiple of 4");
    end
    if (CLA_LAT < 1) begin : g_bad_lat
        $error("cla_nibble_sequencer: CLA_LAT must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [WIDTH-1:0] w_a_sh, w_b_sh, w_sum_d;
    logic             r_cout;
    logic [KW-1:0]    r_k;
    logic [CW-1:0]    r_cnt;
    logic [KW+1:0]    w_base;
    logic             w_accept, w_step, w_last;

    assign w_accept = in_valid && in_ready;
    assign w_step   = (r_state == StRun) && (r_cnt == CW'(CLA_LAT - 1));
    assign w_last   = w_step && (r_k == KW'(N - 1));
    assign w_a_sh   = r_a >> 4;
    assign w_b_sh   = r_b >> 4;
    assign w_base   = {r_k, 2'b00};

    // Sum with the current CLA result merged into nibble k
    always_comb begin
        w_sum_d = r_sum;
        w_sum_d[w_base +: 4] = cla_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept)  w_state_d = StRun;
            StRun:   if (w_last)    w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst && r_state == StIdle) in_ready = 1'b1;
        if (r_state == StDone)         out_valid = 1'b1;
    end

    // Operands are kept as shift registers so the live nibble is always at the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_k     <= '0;
            r_cnt   <= '0;
            cla_a   <= 4'h0;
            cla_b   <= 4'h0;
            cla_cin <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_k     <= '0;
            r_cnt   <= '0;
            cla_a   <= in_a[3:0];
            cla_b   <= in_b[3:0];
            cla_cin <= in_cin;
        end else if (r_state == StRun) begin
            if (w_step) begin
                r_sum <= w_sum_d;
                r_cnt <= '0;
                if (w_last) begin
                    r_cout  <= cla_cout;
                    cla_a   <= 4'h0;
                    cla_b   <= 4'h0;
                    cla_cin <= 1'b0;
                end else begin
                    r_k     <= r_k + 1'b1;
                    r_a     <= w_a_sh;
                    r_b     <= w_b_sh;
                    cla_a   <= w_a_sh[3:0];
                    cla_b   <= w_b_sh[3:0];
                    cla_cin <= cla_cout;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;

`ifdef CLA_SELFCHECK_EN
    logic [WIDTH:0] r_gold;
    logic           r_chk_err;

    // Compare against the value being written on the DONE-entry edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gold    <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gold <= {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
            end
            if (w_last && ({cla_cout, w_sum_d} != r_gold)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Randomised bench for cla_nibble_sequencer with a registered CLA stage, a cycle-level
// reference model and per-cycle comparison of every output.
module tb_cla_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;
    localparam int N     = WIDTH / 4;
`ifdef CLA_SELFCHECK_EN
    localparam bit SelfCheck = 1'b1;
`else
    localparam bit SelfCheck = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [3:0]  cla_a, cla_b, st_s;
    logic        cla_cin, st_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        chk_err;
    bit          inj_en = 1'b0;

    int errors = 0;
    int checks = 0;

    cla_nibble_sequencer #(.WIDTH(WIDTH), .CLA_LAT(LAT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_s     (st_s),
        .cla_cout  (st_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // Registered CLA stage; optional bit-0 fault when the nibble under test is 0xA
    logic [4:0] st_t;
    always @(posedge clk) begin
        st_t = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);
        if (inj_en && cla_a == 4'hA) st_t[0] = ~st_t[0];
        {st_cout, st_s} <= st_t;
    end

    // Reference model: mode 0 idle, 1 busy, 2 result held
    int          m_mode = 0;
    int          m_cyc  = 0;
    logic [16:0] m_a = '0, m_b = '0, m_gold = '0, m_res = '0;
    logic [15:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic        m_chk = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_cyc  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_chk  <= 1'b0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_mode <= 1;
                    m_cyc  <= 0;
                    m_a    <= 17'(in_a);
                    m_b    <= 17'(in_b);
                    m_gold <= 17'(in_a) + 17'(in_b) + 17'(in_cin);
                    m_res  <= (17'(in_a) + 17'(in_b) + 17'(in_cin)) ^ (inj_en ? 17'h100 : 17'h0);
                end
                1: if (m_cyc == N * LAT - 1) begin
                    m_mode <= 2;
                    {m_cout, m_sum} <= m_res;
                    if (SelfCheck && m_res != m_gold) m_chk <= 1'b1;
                end else begin
                    m_cyc <= m_cyc + 1;
                end
                default: if (out_ready) m_mode <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    int idx;
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_mode == 0 && !rst));
        check("out_valid", 32'(out_valid), 32'(m_mode == 2));
        check("chk_err", 32'(chk_err), 32'(m_chk));
        if (m_mode != 1) begin
            check("out_sum", 32'(out_sum), 32'(m_sum));
            check("out_cout", 32'(out_cout), 32'(m_cout));
            check("cla_a_idle", 32'(cla_a), 32'd0);
            check("cla_b_idle", 32'(cla_b), 32'd0);
            check("cla_cin_idle", 32'(cla_cin), 32'd0);
        end else begin
            idx = m_cyc / LAT;
            check("cla_a", 32'(cla_a), 32'((m_a >> (4 * idx)) & 17'hF));
            check("cla_b", 32'(cla_b), 32'((m_b >> (4 * idx)) & 17'hF));
            check("cla_cin", 32'(cla_cin), 32'(((m_gold ^ m_a ^ m_b) >> (4 * idx)) & 17'h1));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit inj);
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        inj_en   = inj;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [16:0] exp);
        int lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(N * LAT));
        check("result_sum", 32'(out_sum), 32'(exp[15:0]));
        check("result_cout", 32'(out_cout), 32'(exp[16]));
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit inj, input bit pre, input int dly);
        logic [16:0] exp;
        exp = 17'(a) + 17'(b) + 17'(cin);
        if (inj) exp[8] = ~exp[8];
        send(a, b, cin, inj);
        if (pre) out_ready = 1'b1;
        wait_result(exp);
        if (!pre) begin
            repeat (dly) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        inj_en    = 1'b0;
        check("hs_valid_drop", 32'(out_valid), 32'd0);
        check("hs_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sum", 32'(out_sum), 32'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0);

        // Backpressure with a competing request held high
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_result(17'h01010);
        repeat (10) begin
            in_valid = 1'b1;
            in_a     = 16'h1111;
            in_b     = 16'h1111;
            in_cin   = 1'b0;
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'h1010);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_reaccept", 32'(in_ready), 32'd0);
        wait_result(17'h02222);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous abort mid-operation
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cla_a", 32'(cla_a), 32'd0);
        check("rst_cla_b", 32'(cla_b), 32'd0);
        check("rst_cla_cin", 32'(cla_cin), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0);

        // Fault on nibble 2, then a clean operation
        do_op(16'h0A00, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
        check("chk_after_fault", 32'(chk_err), 32'(SelfCheck));
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 2);
        check("chk_sticky", 32'(chk_err), 32'(SelfCheck));
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("chk_cleared", 32'(chk_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                  ($urandom % 4) == 0, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
